// File: rtl/morse_pkg.sv
// Shared definitions for the Morse LED transmit path.
// Holds the arbiter state encoding, source indices, counter widths
// and a small one-hot helper used to build grant vectors.
package morse_pkg;

    localparam int unsigned TICK_W     = 4;   // half-second counter width
    localparam int unsigned TCNT_W     = 8;   // per-grant tick counter width
    localparam int unsigned GAP_W      = 4;   // word-gap counter width

    localparam int unsigned SRC_KEYPAD = 0;
    localparam int unsigned SRC_REPLY  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Build a one-hot grant vector from a source index.
    function automatic logic [1:0] src_onehot(input logic src);
        logic [1:0] v;
        v      = 2'b00;
        v[src] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/morse_tick_detect.sv
// Half-second tick detector.
// Registers the free-running half-second counter and raises a one-cycle
// pulse on the cycle after any change of value (wrap 15->0 included).
// Ports:
//   iCLK, iRST  clock, asynchronous active-high reset
//   iHalfSec    free-running half-second counter
//   oTick       registered one-cycle tick pulse
module morse_tick_detect
    import morse_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [TICK_W-1:0] iHalfSec,
    output logic              oTick
);

    logic [TICK_W-1:0] r_prev;
    logic              r_tick;

    // Previous-value register and registered change flag.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_prev <= '0;
            r_tick <= 1'b0;
        end else begin
            r_prev <= iHalfSec;
            r_tick <= (iHalfSec != r_prev);
        end
    end

    assign oTick = r_tick;

endmodule

// File: rtl/morse_tx_arbiter.sv
// Morse LED channel arbiter.
// Shares one LED between the keypad transmitter (source 0) and the
// auto-reply/beacon generator (source 1). Requests are arbitrated
// round-robin in IDLE; the granted source is advanced once per
// half-second tick and its bit is muxed onto the LED. Every message is
// followed by a silent word gap of GAP_TICKS ticks.
// Optional watchdog: define MORSE_ARB_TIMEOUT_EN to revoke a grant that
// runs MAX_TICKS ticks without iDone (oTimeout pulses once).
// Ports:
//   iCLK, iRST  clock, asynchronous active-high reset
//   iHalfSec    half-second counter; each value change is one tick
//   iReq        level request per source
//   iDone       end-of-message per source (granted source only)
//   iBit        current bit per source
//   oGrant      one-hot grant or 0
//   oTickEn     advance pulse to the granted source
//   oLED        transmitted bit
//   oBusy       high in SEND or GAP
//   oState      0 IDLE, 1 SEND, 2 GAP
//   oTimeout    one-cycle pulse when the watchdog revokes a grant
module morse_tx_arbiter
    import morse_pkg::*;
#(
    parameter int unsigned GAP_TICKS = 7,
    parameter int unsigned MAX_TICKS = 140
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [TICK_W-1:0] iHalfSec,
    input  logic [1:0]        iReq,
    input  logic [1:0]        iDone,
    input  logic [1:0]        iBit,
    output logic [1:0]        oGrant,
    output logic              oTickEn,
    output logic              oLED,
    output logic              oBusy,
    output logic [1:0]        oState,
    output logic              oTimeout
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_grant;
    logic [1:0]       w_grant_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;

    logic             w_tick;
    logic             w_src;
    logic             w_done;
    logic             w_abort;
    logic             w_wd;
    logic             w_end;
    logic             w_pick;

    morse_tick_detect u_tick (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iHalfSec (iHalfSec),
        .oTick    (w_tick)
    );

    // Index of the currently granted source (only meaningful in SEND).
    assign w_src   = r_grant[SRC_REPLY];
    assign w_done  = iDone[w_src];
    assign w_abort = ~iReq[w_src];
    assign w_end   = w_done | w_abort | w_wd;

    // Single requester wins outright; on a tie the source not served last wins.
    always_comb begin
        w_pick = ~r_last;
        if (iReq == 2'b01) begin
            w_pick = 1'(SRC_KEYPAD);
        end else if (iReq == 2'b10) begin
            w_pick = 1'(SRC_REPLY);
        end
    end

`ifdef MORSE_ARB_TIMEOUT_EN
    logic [TCNT_W-1:0] r_tick_cnt;
    logic              r_timeout;

    // Fires on the tick that brings this grant's tick count to MAX_TICKS.
    assign w_wd = w_tick && (r_tick_cnt == TCNT_W'(MAX_TICKS - 1));

    // Ticks consumed by the current grant; cleared whenever SEND ends.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_tick_cnt <= '0;
        end else if (r_state == ST_SEND) begin
            if (w_end) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // iDone in the same cycle as the watchdog suppresses the timeout.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == ST_SEND) && w_wd && !w_done;
        end
    end

    assign oTimeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_wd         = 1'b0;
    assign oTimeout     = 1'b0;
    assign w_unused_cfg = ^TCNT_W'(MAX_TICKS);
`endif

    // State, grant, last-served and gap counter registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'b00;
            r_last    <= 1'(SRC_REPLY);
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|iReq) begin
                    w_state_nxt = ST_SEND;
                    w_grant_nxt = src_onehot(w_pick);
                end
            end
            ST_SEND: begin
                if (w_end) begin
                    w_state_nxt   = ST_GAP;
                    w_grant_nxt   = 2'b00;
                    w_last_nxt    = w_src;
                    w_gap_cnt_nxt = GAP_W'(GAP_TICKS);
                end
            end
            ST_GAP: begin
                // Zero is tested before decrementing, so a zero-length gap
                // still spends one cycle here.
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    assign oGrant  = r_grant;
    assign oTickEn = w_tick && (r_state == ST_SEND);
    assign oLED    = |(r_grant & iBit);
    assign oBusy   = (r_state != ST_IDLE);
    assign oState  = r_state;

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// Bench for morse_tx_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a message-level model.
module tb_morse_tx_arbiter;

`ifdef MORSE_ARB_TIMEOUT_EN
    localparam bit          TMO_EN = 1'b1;
    localparam int unsigned TB_MAX = 5;
`else
    localparam bit          TMO_EN = 1'b0;
    localparam int unsigned TB_MAX = 140;
`endif
    localparam int unsigned TB_GAP = 7;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [3:0] iHalfSec = 4'd0;
    logic [1:0] iReq = 2'b00;
    logic [1:0] iDone = 2'b00;
    logic [1:0] iBit = 2'b00;

    logic [1:0] oGrant, oState, d0_grant, d0_state;
    logic       oTickEn, oLED, oBusy, oTimeout;
    logic       d0_tick, d0_led, d0_busy, d0_tmo;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    morse_tx_arbiter #(.GAP_TICKS(TB_GAP), .MAX_TICKS(TB_MAX)) u_dut (
        .iCLK(iCLK), .iRST(iRST), .iHalfSec(iHalfSec), .iReq(iReq),
        .iDone(iDone), .iBit(iBit), .oGrant(oGrant), .oTickEn(oTickEn),
        .oLED(oLED), .oBusy(oBusy), .oState(oState), .oTimeout(oTimeout)
    );

    // Zero-gap instance sharing the same stimulus.
    morse_tx_arbiter #(.GAP_TICKS(0), .MAX_TICKS(TB_MAX)) u_dut0 (
        .iCLK(iCLK), .iRST(iRST), .iHalfSec(iHalfSec), .iReq(iReq),
        .iDone(iDone), .iBit(iBit), .oGrant(d0_grant), .oTickEn(d0_tick),
        .oLED(d0_led), .oBusy(d0_busy), .oState(d0_state), .oTimeout(d0_tmo)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Message-level model: who owns the LED, how many silent ticks remain,
    // how many ticks this message has used, and whether a tick is visible.
    int m_phase    = 0;   // 0 idle, 1 sending, 2 word gap
    int m_owner    = 0;
    int m_last     = 1;
    int m_gap_left = 0;
    int m_used     = 0;
    int m_prev     = 0;
    bit m_tick     = 1'b0;
    bit m_tmo      = 1'b0;

    always @(posedge iCLK or posedge iRST) begin : model
        bit tick_now;
        bit wd;
        if (iRST) begin
            m_phase = 0; m_owner = 0; m_last = 1; m_gap_left = 0;
            m_used = 0; m_prev = 0; m_tick = 1'b0; m_tmo = 1'b0;
        end else begin
            tick_now = m_tick;
            m_tmo    = 1'b0;
            if (m_phase == 0) begin
                if (iReq != 2'b00) begin
                    if (iReq == 2'b11) m_owner = 1 - m_last;
                    else               m_owner = (iReq == 2'b10) ? 1 : 0;
                    m_phase = 1;
                    m_used  = 0;
                end
            end else if (m_phase == 1) begin
                wd = TMO_EN && tick_now && (m_used + 1 == int'(TB_MAX));
                if (iDone[m_owner] || !iReq[m_owner] || wd) begin
                    m_tmo      = wd && !iDone[m_owner];
                    m_last     = m_owner;
                    m_phase    = 2;
                    m_gap_left = TB_GAP;
                    m_used     = 0;
                end else if (tick_now) begin
                    m_used++;
                end
            end else begin
                if (m_gap_left == 0) m_phase = 0;
                else if (tick_now)   m_gap_left--;
            end
            m_tick = (int'(iHalfSec) != m_prev);
            m_prev = int'(iHalfSec);
        end
    end

    // Compare every output against the model each cycle.
    always @(negedge iCLK) begin : compare
        logic [1:0] e_grant;
        logic       e_led;
        if (cmp_en) begin
            #2;
            e_grant = (m_phase == 1) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_led   = (m_phase == 1) ? iBit[m_owner] : 1'b0;
            chk("m_grant",   8'(oGrant),   8'(e_grant));
            chk("m_state",   8'(oState),   8'(m_phase));
            chk("m_busy",    8'(oBusy),    8'(m_phase != 0));
            chk("m_tickEn",  8'(oTickEn),  8'(m_tick && m_phase == 1));
            chk("m_led",     8'(oLED),     8'(e_led));
            chk("m_timeout", 8'(oTimeout), 8'(m_tmo));
        end
    end

    // Asserts reset at the current time and releases it two negedges later.
    task automatic do_reset();
        iRST = 1'b1; iReq = 2'b00; iDone = 2'b00; iBit = 2'b00; iHalfSec = 4'd0;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    initial begin
        int pulses;
        int led_hi;

        // Reset values and single request.
        do_reset();
        cmp_en = 1'b1;
        chk("rst_grant", 8'(oGrant), 8'd0);
        chk("rst_state", 8'(oState), 8'd0);
        chk("rst_busy",  8'(oBusy),  8'd0);
        chk("rst_tick",  8'(oTickEn), 8'd0);
        chk("rst_led",   8'(oLED),   8'd0);
        chk("rst_tmo",   8'(oTimeout), 8'd0);
        iReq = 2'b01;
        @(negedge iCLK);
        chk("req_grant", 8'(oGrant), 8'd1);
        chk("req_state", 8'(oState), 8'd1);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            iHalfSec = iHalfSec + 4'd1;
            iBit     = 2'(k + 1);
            @(negedge iCLK);
            if (oTickEn) pulses++;
            chk("led_follow", 8'(oLED), 8'(iBit[0]));
            @(negedge iCLK);
            if (oTickEn) pulses++;
        end
        chk("tick_pulses", 8'(pulses), 8'd3);

        // Tie from reset, done, 7-tick gap, then round-robin to source 1.
        do_reset();
        iReq = 2'b11;
        @(negedge iCLK);
        chk("tie_grant", 8'(oGrant), 8'd1);
        iDone = 2'b01;
        @(negedge iCLK);
        chk("done_grant", 8'(oGrant), 8'd0);
        chk("done_state", 8'(oState), 8'd2);
        iDone = 2'b00;
        for (int k = 0; k < 7; k++) begin
            iHalfSec = iHalfSec + 4'd1;
            @(negedge iCLK);
            @(negedge iCLK);
        end
        chk("gap_last", 8'(oState), 8'd2);
        @(negedge iCLK);
        chk("gap_idle", 8'(oState), 8'd0);
        @(negedge iCLK);
        chk("rr_grant", 8'(oGrant), 8'd2);

        // Abort source 1 mid-message; LED silent through the gap.
        iBit = 2'b11;
        @(negedge iCLK);
        chk("src1_led", 8'(oLED), 8'd1);
        iReq = 2'b01;
        @(negedge iCLK);
        chk("abort_state", 8'(oState), 8'd2);
        chk("abort_grant", 8'(oGrant), 8'd0);
        led_hi = 0;
        for (int k = 0; k < 7; k++) begin
            iHalfSec = iHalfSec + 4'd1;
            @(negedge iCLK);
            if (oLED) led_hi++;
            @(negedge iCLK);
            if (oLED) led_hi++;
        end
        chk("gap_silent", 8'(led_hi), 8'd0);
        @(negedge iCLK);
        @(negedge iCLK);
        chk("after_abort_grant", 8'(oGrant), 8'd1);

        // Zero-length gap on the second instance.
        do_reset();
        iReq = 2'b01;
        @(negedge iCLK);
        chk("g0_grant", 8'(d0_grant), 8'd1);
        iDone = 2'b01;
        @(negedge iCLK);
        chk("g0_gap", 8'(d0_state), 8'd2);
        iDone = 2'b00;
        @(negedge iCLK);
        chk("g0_idle", 8'(d0_state), 8'd0);
        @(negedge iCLK);
        chk("g0_regrant", 8'(d0_grant), 8'd1);
        chk("g0_send", 8'(d0_state), 8'd1);

`ifdef MORSE_ARB_TIMEOUT_EN
        // Watchdog fires on the fifth tick.
        do_reset();
        iReq = 2'b01;
        @(negedge iCLK);
        for (int k = 0; k < 5; k++) begin
            iHalfSec = iHalfSec + 4'd1;
            @(negedge iCLK);
            @(negedge iCLK);
        end
        chk("wd_state", 8'(oState), 8'd2);
        chk("wd_tmo", 8'(oTimeout), 8'd1);
        @(negedge iCLK);
        chk("wd_tmo_once", 8'(oTimeout), 8'd0);

        // iDone together with the fifth tick wins over the watchdog.
        do_reset();
        iReq = 2'b01;
        @(negedge iCLK);
        for (int k = 0; k < 4; k++) begin
            iHalfSec = iHalfSec + 4'd1;
            @(negedge iCLK);
            @(negedge iCLK);
        end
        iHalfSec = iHalfSec + 4'd1;
        @(negedge iCLK);
        iDone = 2'b01;
        @(negedge iCLK);
        chk("wd_done_state", 8'(oState), 8'd2);
        chk("wd_done_tmo", 8'(oTimeout), 8'd0);
        iDone = 2'b00;
`endif

        // Asynchronous reset during SEND.
        do_reset();
        iReq = 2'b01;
        iBit = 2'b01;
        @(negedge iCLK);
        chk("pre_rst_grant", 8'(oGrant), 8'd1);
        #3;
        iRST = 1'b1;
        #1;
        chk("arst_grant", 8'(oGrant), 8'd0);
        chk("arst_state", 8'(oState), 8'd0);
        chk("arst_busy",  8'(oBusy),  8'd0);
        chk("arst_led",   8'(oLED),   8'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        iReq = 2'b11;
        @(negedge iCLK);
        chk("post_rst_grant", 8'(oGrant), 8'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) iHalfSec = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) iReq = 2'($urandom_range(0, 3));
            iDone = 2'b00;
            if ($urandom_range(0, 11) == 0) iDone = 2'($urandom_range(1, 3));
            iBit = 2'($urandom_range(0, 3));
            iRST = ($urandom_range(0, 499) == 0);
            @(negedge iCLK);
        end
        iRST = 1'b0;
        @(negedge iCLK);
        #4;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/morse_tx_arbiter.md
# morse_tx_arbiter

Shares the single Morse optical LED channel between two bit-stream sources: source 0 is the keypad transmitter and source 1 is the auto-reply/beacon generator. A request/grant handshake selects the sources round-robin. The block emits a per-tick advance pulse to the granted source, muxes that source's bit onto the LED, and enforces a silent word gap between consecutive messages. It sits between the transmit sources and the board LED and is clocked by the system clock and the shared half-second counter.

## Interface
- GAP_TICKS, default 7: silent ticks inserted after each message (Morse word gap); legal range 0–15.
- MAX_TICKS, default 140: watchdog limit in ticks per grant; matches the 140-bit source buffer; legal range 1–255.
- iCLK  in  1  system clock.
- iRST  in  1  reset, asynchronous, active-high; clock iCLK.
- iHalfSec  in  4  free-running half-second counter; any value change equals one tick.
- iReq  in  2  level request per source; bit 0 = keypad TX, bit 1 = auto-reply.
- iDone  in  2  per-source end-of-message indication; sampled only for the granted source.
- iBit  in  2  current bit driven by each source.
- oGrant  out  2  one-hot grant, or 0.
- oTickEn  out  1  one-cycle pulse; the granted source advances its bit index.
- oLED  out  1  transmitted bit.
- oBusy  out  1  high in SEND or GAP.
- oState  out  2  0 = IDLE, 1 = SEND, 2 = GAP.
- oTimeout  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- Tick detect: prev register holds iHalfSec. tick = (iHalfSec != prev), registered, so the tick pulse is high one cycle after the change.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one request, grant that source.
  - With both requesting, grant the source other than `last` (the last-granted source). `last` resets to 1, so source 0 wins the first tie.
  - Grant is registered: oGrant goes high and the state moves to SEND on the cycle after the request is seen.
- SEND:
  - oLED = iBit[g] (combinational from oGrant & iBit).
  - oTickEn = tick.
  - tick_cnt (8 bit) increments on each tick.
- SEND → GAP occurs when any of the following holds:
  - iDone[g] is high;
  - iReq[g] drops (abort);
  - watchdog fires.
- On entering GAP:
  - oGrant clears;
  - `last` is set to g;
  - gap_cnt is loaded with GAP_TICKS;
  - tick_cnt is cleared.
- GAP:
  - oLED = 0 and oTickEn = 0.
  - gap_cnt decrements on each tick.
  - At gap_cnt == 0, go to IDLE (checked on entry, so GAP_TICKS = 0 costs exactly one GAP cycle).
- Requests arriving during SEND or GAP are held (they are levels) and arbitrated in IDLE.
- Simultaneous events:
  - iDone together with watchdog: done wins and oTimeout stays 0.
  - iDone together with tick in the same cycle: oTickEn still pulses, then SEND → GAP.
- The non-granted iDone and iBit are ignored.

## Timing
- Reset values:
  - oGrant = 0, oTickEn = 0, oLED = 0, oBusy = 0, oState = IDLE, oTimeout = 0;
  - prev = 0, `last` = 1, tick_cnt = 0, gap_cnt = 0.
- Reset mid-operation forces IDLE immediately. Sources must treat a lost grant as an abort.
- Latency:
  - request to grant: 1 cycle;
  - iHalfSec change to oTickEn: 1 cycle;
  - iDone to oGrant low: 1 cycle.
- An iHalfSec wrap from 15 to 0 is a change and counts as a tick.
- The first iHalfSec sample after reset counts as a tick if it is nonzero; this is harmless in IDLE.

## Configuration
- MORSE_ARB_TIMEOUT_EN defined:
  - When tick_cnt reaches MAX_TICKS in SEND without iDone, the block pulses oTimeout for one cycle and goes to GAP.
- MORSE_ARB_TIMEOUT_EN undefined:
  - No watchdog; a grant persists until iDone or the request drops.
  - oTimeout is tied to 0 and tick_cnt is not synthesized.

## Structure
- Package morse_pkg holds:
  - the state encoding (IDLE/SEND/GAP);
  - source index constants SRC_KEYPAD = 0 and SRC_REPLY = 1;
  - the tick width of 4 and the tick-count width of 8.
- One sub-module, morse_tick_detect: the iHalfSec change detector with a registered one-cycle pulse, reusable by RX.

## Test plan
- Reset, then iReq = 01 → oGrant = 01 after 1 cycle. Toggle iHalfSec 3 times → 3 oTickEn pulses, and oLED follows iBit[0].
- iReq = 11 from reset → source 0 granted. Assert iDone[0], then wait 7 ticks → IDLE, then source 1 granted (round-robin).
- Grant source 1, drop iReq[1] mid-message → GAP next cycle, with oLED = 0 throughout GAP.
- GAP_TICKS = 0: iDone → one GAP cycle → IDLE, and a pending request is granted on the following cycle.
- MORSE_ARB_TIMEOUT_EN with MAX_TICKS = 5: hold the grant without iDone for 5 ticks → oTimeout pulses once, then GAP. Repeat with iDone in the 5th-tick cycle → no oTimeout.
- Assert iRST during SEND → all outputs 0 and oState = IDLE asynchronously. After release, iReq = 11 grants source 0.
